// File: rtl/dm_store_ctrl.sv
// Store master for a word-only data memory: word stores write directly, half/byte stores read-modify-write.
// Optional `DM_STORE_TRACE_EN prints one trace line per committed write.
module dm_store_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        OP_WORD = 2'd0,
        OP_HALF = 2'd1,
        OP_BYTE = 2'd2,
        OP_ILL  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE
    } state_e;

    state_e      state;
    op_e         op_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic [31:0] merged;
    logic        aligned;
    op_e         req_op_e;

    assign req_op_e  = op_e'(req_op);
    assign req_ready = (state == S_IDLE) && !reset;

    always_comb begin
        aligned = 1'b0;
        unique case (req_op_e)
            OP_WORD: aligned = (req_addr[1:0] == 2'b00);
            OP_HALF: aligned = !req_addr[0];
            OP_BYTE: aligned = 1'b1;
            default: aligned = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: default assignment first, so every path leaves merged defined and no latch is inferred.
        merged = mem_rd;
        case (op_q)
            OP_HALF: begin
                if (lane_q[1])
                    merged[31:16] = wdata_q;
                else
                    merged[15:0] = wdata_q;
            end
            OP_BYTE: merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
            default: merged = mem_rd;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
        if (reset) begin
            state    <= S_IDLE;
            mem_addr <= '0;
            mem_wd   <= '0;
            mem_we   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            op_q     <= OP_WORD;
            lane_q   <= '0;
            wdata_q  <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (!aligned) begin
                            err <= 1'b1;
                        end else begin
                            mem_addr <= {req_addr[31:2], 2'b00};
                            lane_q   <= req_addr[1:0];
                            op_q     <= req_op_e;
                            wdata_q  <= req_wdata[15:0];
                            if (req_op_e == OP_WORD) begin
                                mem_wd <= req_wdata;
                                mem_we <= 1'b1;
                                done   <= 1'b1;
                                state  <= S_WRITE;
                            end else begin
                                state <= S_READ;
                            end
                        end
                    end
                end
                // mem_rd reflects mem_addr during READ; the merged word is captured here.
                S_READ: begin
                    mem_wd <= merged;
                    mem_we <= 1'b1;
                    done   <= 1'b1;
                    state  <= S_WRITE;
                end
                S_WRITE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DM_STORE_TRACE_EN
    logic [31:0] pc_q;

    always_ff @(posedge clk) begin
        if (reset)
            pc_q <= '0;
        else if (req_ready && req_valid && aligned)
            pc_q <= req_pc;
        if (state == S_WRITE)
            $display("@%h: *%h <= %h", pc_q, mem_addr, mem_wd);
    end
`else
    logic unused_pc;
    assign unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_dm_store_ctrl.sv
// Self-checking bench for dm_store_ctrl: directed cases then random stores against a word-array reference.
module tb_dm_store_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem     [0:15];
    logic [31:0] ref_mem [0:15];
    logic        pre_we;
    logic [3:0]  pre_idx;
    logic [31:0] pre_val;

    always #5 clk = ~clk;

    dm_store_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_pc    (req_pc),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd),
        .done      (done),
        .err       (err)
    );

    // Word-only memory: combinational read, write commits at the clock edge.
    assign mem_rd = mem[mem_addr[5:2]];
    always @(posedge clk) begin
        if (mem_we)
            mem[mem_addr[5:2]] <= mem_wd;
        else if (pre_we)
            mem[pre_idx] <= pre_val;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        pre_we  = 1'b1;
        pre_idx = idx[3:0];
        pre_val = val;
        @(posedge clk);
        @(negedge clk);
        pre_we  = 1'b0;
        ref_mem[idx] = val;
    endtask

    // Expected word after a store, from the byte-lane rules alone.
    function automatic logic [31:0] ref_merge(input logic [1:0] op, input logic [31:0] addr,
                                              input logic [31:0] wd, input logic [31:0] old);
        int sh;
        case (op)
            2'd0: return wd;
            2'd1: begin
                sh = 16 * int'(addr[1]);
                return (old & ~(32'h0000FFFF << sh)) | ((wd & 32'h0000FFFF) << sh);
            end
            default: begin
                sh = 8 * int'(addr[1:0]);
                return (old & ~(32'h000000FF << sh)) | ((wd & 32'h000000FF) << sh);
            end
        endcase
    endfunction

    function automatic bit ref_legal(input logic [1:0] op, input logic [31:0] addr);
        return (op == 2'd0 && addr % 4 == 0) || (op == 2'd1 && addr % 2 == 0) || (op == 2'd2);
    endfunction

    // Issue one store from an idle cycle and check every cycle until ready returns.
    task automatic do_store(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd);
        int          idx;
        logic [31:0] old;
        logic [31:0] exp;
        idx = int'(addr[5:2]);
        old = ref_mem[idx];
        exp = ref_merge(op, addr, wd, old);
        check("ready_before", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        req_pc    = $urandom;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        if (!ref_legal(op, addr)) begin
            check("rej_err", {31'd0, err}, 32'd1);
            check("rej_we", {31'd0, mem_we}, 32'd0);
            check("rej_ready", {31'd0, req_ready}, 32'd1);
            @(negedge clk);
            check("rej_err_clr", {31'd0, err}, 32'd0);
            check("rej_we2", {31'd0, mem_we}, 32'd0);
            check("rej_mem", mem[idx], old);
        end else if (op == 2'd0) begin
            check("w_we", {31'd0, mem_we}, 32'd1);
            check("w_done", {31'd0, done}, 32'd1);
            check("w_addr", mem_addr, {addr[31:2], 2'b00});
            check("w_wd", mem_wd, exp);
            check("w_ready", {31'd0, req_ready}, 32'd0);
            check("w_err", {31'd0, err}, 32'd0);
            @(negedge clk);
            check("w_we_clr", {31'd0, mem_we}, 32'd0);
            check("w_done_clr", {31'd0, done}, 32'd0);
            check("w_ready_back", {31'd0, req_ready}, 32'd1);
            check("w_mem", mem[idx], exp);
            ref_mem[idx] = exp;
        end else begin
            check("rd_we", {31'd0, mem_we}, 32'd0);
            check("rd_done", {31'd0, done}, 32'd0);
            check("rd_addr", mem_addr, {addr[31:2], 2'b00});
            check("rd_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
            check("sw_we", {31'd0, mem_we}, 32'd1);
            check("sw_done", {31'd0, done}, 32'd1);
            check("sw_wd", mem_wd, exp);
            check("sw_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
            check("sw_we_clr", {31'd0, mem_we}, 32'd0);
            check("sw_ready_back", {31'd0, req_ready}, 32'd1);
            check("sw_mem", mem[idx], exp);
            ref_mem[idx] = exp;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [1:0]  rop;
        logic [31:0] raddr;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_addr  = '0;
        req_wdata = '0;
        req_pc    = '0;
        pre_we    = 1'b0;
        pre_idx   = '0;
        pre_val   = '0;

        @(negedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wd", mem_wd, 32'd0);
        for (int i = 0; i < 16; i++) preload(i, $urandom);
        reset = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Directed cases.
        do_store(2'd0, 32'h0000_0010, 32'hDEAD_BEEF);
        check("word4_deadbeef", mem[4], 32'hDEAD_BEEF);
        preload(4, 32'h1122_3344);
        do_store(2'd2, 32'h0000_0012, 32'h0000_00AB);
        check("word4_byte", mem[4], 32'h11AB_3344);
        preload(4, 32'h1122_3344);
        do_store(2'd1, 32'h0000_0012, 32'h0000_CAFE);
        check("word4_half_hi", mem[4], 32'hCAFE_3344);
        do_store(2'd1, 32'h0000_0010, 32'h0000_BEEF);
        check("word4_half_lo", mem[4], 32'hCAFE_BEEF);
        do_store(2'd0, 32'h0000_0011, 32'h1234_5678);
        do_store(2'd1, 32'h0000_0013, 32'h1234_5678);
        do_store(2'd3, 32'h0000_0010, 32'h1234_5678);
        check("word4_after_rejects", mem[4], 32'hCAFE_BEEF);

        // Reset during READ drops the store.
        req_valid = 1'b1;
        req_op    = 2'd2;
        req_addr  = 32'h0000_0011;
        req_wdata = 32'h0000_0077;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        check("mid_rst_we", {31'd0, mem_we}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_err", {31'd0, err}, 32'd0);
        check("mid_rst_addr", mem_addr, 32'd0);
        check("mid_rst_wd", mem_wd, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
        // A request presented while reset is high is not accepted.
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_addr  = 32'h0000_0010;
        req_wdata = 32'h0BAD_0BAD;
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b0;
        check("rst_req_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        check("rst_req_we2", {31'd0, mem_we}, 32'd0);
        check("mid_rst_ready_back", {31'd0, req_ready}, 32'd1);
        check("mid_rst_mem", mem[4], 32'hCAFE_BEEF);

        // Back-to-back byte stores with req_valid held high.
        preload(8, 32'h0000_0000);
        req_valid = 1'b1;
        req_op    = 2'd2;
        req_addr  = 32'h0000_0020;
        req_wdata = 32'h0000_0055;
        @(posedge clk);
        @(negedge clk);
        req_addr  = 32'h0000_0023;
        req_wdata = 32'h0000_00AA;
        cyc = 1;
        while (!req_ready && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_ready_gap", cyc, 3);
        check("b2b_first", mem[8], 32'h0000_0055);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_second_read", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("b2b_second_we", {31'd0, mem_we}, 32'd1);
        @(negedge clk);
        check("b2b_final", mem[8], 32'hAA00_0055);
        ref_mem[8] = 32'hAA00_0055;

        // Random stores over the 16-word window.
        for (int n = 0; n < 80; n++) begin
            rop   = 2'($urandom_range(0, 3));
            raddr = {26'd0, 6'($urandom)};
            if ($urandom_range(0, 3) != 0 && rop != 2'd2) begin
                if (rop == 2'd0) raddr[1:0] = 2'b00;
                if (rop == 2'd1) raddr[0]   = 1'b0;
            end
            do_store(rop, raddr, $urandom);
        end
        for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
